ysyx_23060077_ex_mul: RTL

- Multi-cycle radix-2 shift-add multiplier in the EX stage for RV32M MUL/MULH/MULHSU/MULHU.
- Inverse-operation companion of the EX-stage divider; uses the same valid/ready/out_valid/flush handshake toward the EX controller.
- Returns the full 64-bit product split into lo/hi words. The EX controller selects lo for MUL and hi for the MULH variants.

---
 rtl/ysyx_23060077_ex_mul.sv | 130 +++++++++++++
 1 files changed

// File: rtl/ysyx_23060077_ex_mul.sv
// ysyx_23060077_ex_mul: EX-stage multi-cycle radix-2 shift-add multiplier for RV32M
// MUL/MULH/MULHSU/MULHU. Magnitudes of the operands are multiplied unsigned, and the
// sign is applied to the 64-bit result in a separate cycle.
//
// Optional build macro: YSYX_23060077_MUL_EARLY_EXIT_EN
//   When defined, the iteration loop stops as soon as no multiplier bits remain.
//   Results are unchanged; only the latency differs.
//
// Ports:
//   clock         system clock, rising edge
//   reset         synchronous active-low reset
//   mul_signed    [1] multiplicand signed, [0] multiplier signed
//   multiplicand  operand a (rs1)
//   multiplier    operand b (rs2)
//   flush         abort any operation in flight
//   mul_valid     request, operands sampled on accept
//   mul_ready     idle and able to accept
//   out_valid     one-cycle pulse, product valid
//   product_lo    product[31:0]
//   product_hi    product[63:32]
module ysyx_23060077_ex_mul #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            mul_signed,
  input  logic [DATA_WIDTH-1:0] multiplicand,
  input  logic [DATA_WIDTH-1:0] multiplier,
  input  logic                  flush,
  input  logic                  mul_valid,
  output logic                  mul_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] product_lo,
  output logic [DATA_WIDTH-1:0] product_hi
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StAns, StEnd} state_e;

  state_e                  state;
  logic                    sa;
  logic                    sb;
  logic [2*DATA_WIDTH-1:0] acc;
  logic [2*DATA_WIDTH-1:0] mcand;
  logic [DATA_WIDTH-1:0]   mplier;
  logic [CntW-1:0]         count;

  logic                    a_neg;
  logic                    b_neg;
  logic [DATA_WIDTH-1:0]   a_abs;
  logic [DATA_WIDTH-1:0]   b_abs;
  logic [2*DATA_WIDTH-1:0] acc_next;
  logic [2*DATA_WIDTH-1:0] acc_neg;
  logic                    calc_done;

  always_comb begin
    a_neg    = mul_signed[1] & multiplicand[DATA_WIDTH-1];
    b_neg    = mul_signed[0] & multiplier[DATA_WIDTH-1];
    // The most negative value negates to itself and is then read as unsigned.
    a_abs    = a_neg ? (~multiplicand + 1'b1) : multiplicand;
    b_abs    = b_neg ? (~multiplier + 1'b1) : multiplier;
    acc_next = mplier[0] ? (acc + mcand) : acc;
    acc_neg  = ~acc + 1'b1;
`ifdef YSYX_23060077_MUL_EARLY_EXIT_EN
    // Stop once the shifted multiplier holds no more set bits.
    calc_done = (count == '0) || (mplier[DATA_WIDTH-1:1] == '0);
`else
    calc_done = (count == '0);
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= StIdle;
      mul_ready  <= 1'b0;
      out_valid  <= 1'b0;
      product_lo <= '0;
      product_hi <= '0;
      sa         <= 1'b0;
      sb         <= 1'b0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      count      <= '0;
    end else if (flush && (state != StIdle)) begin
      // Aborted op: no pulse, product registers keep their last value.
      state     <= StIdle;
      out_valid <= 1'b0;
      mul_ready <= 1'b1;
    end else begin
      unique case (state)
        StIdle: begin
          mul_ready <= 1'b1;
          out_valid <= 1'b0;
          if (mul_valid && mul_ready && !flush) begin
            mul_ready <= 1'b0;
            sa        <= a_neg;
            sb        <= b_neg;
            acc       <= '0;
            mcand     <= {{DATA_WIDTH{1'b0}}, a_abs};
            mplier    <= b_abs;
            count     <= CntW'(DATA_WIDTH - 1);
            state     <= StCalc;
          end
        end
        StCalc: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count - 1'b1;
          if (calc_done) begin
            state <= StAns;
          end
        end
        StAns: begin
          {product_hi, product_lo} <= (sa ^ sb) ? acc_neg : acc;
          state                    <= StEnd;
        end
        StEnd: begin
          out_valid <= 1'b1;
          mul_ready <= 1'b1;
          state     <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
